// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND digit-scan logic.
package fnd_pkg;

    // Digit enables are driven low to light a common-anode digit.
    localparam bit FND_ACTIVE_LOW = 1'b1;

    // Widest digit bus the helpers below can describe.
    localparam int unsigned MAX_DIGITS = 32;

    // Phase within one digit slot, decoded from the prescaler count.
    typedef enum logic [1:0] {
        PHASE_DEAD = 2'd0,
        PHASE_ON   = 2'd1,
        PHASE_TAIL = 2'd2
    } slot_phase_e;

    // Digit-enable pattern with every one of n digits switched off.
    function automatic logic [MAX_DIGITS-1:0] all_off(input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (k < n) v[k] = FND_ACTIVE_LOW;
        end
        return v;
    endfunction

    // Counter width that stays at least one bit even for n <= 1.
    function automatic int unsigned safe_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler and digit index counter with combinational wrap strobes.
module scan_prescaler
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 4,
    localparam int unsigned CNT_W     = safe_width(SCAN_DIV),
    localparam int unsigned SEL_W     = safe_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic [SEL_W-1:0] sel,
    output logic             slotWrap_c,
    output logic             frameWrap_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    // Last cycle of a slot, and last cycle of the last slot in a frame.
    assign slotWrap_c  = (cnt == CNT_LAST);
    assign frameWrap_c = slotWrap_c && (sel == SEL_LAST);

    // Free-running slot counter; the digit index advances on each slot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sel <= '0;
        end else if (slotWrap_c) begin
            cnt <= '0;
            sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed FND digit scanner with dead time, blanking, masking and dimming.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned DIM_SHIFT   = 2,
    localparam int unsigned SEL_W      = safe_width(NUM_DIGITS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_SW_FndLight,
    input  logic [NUM_DIGITS-1:0] i_digit_mask,
    output logic [NUM_DIGITS-1:0] o_digitPosition,
    output logic [SEL_W-1:0]      o_select,
    output logic                  o_tick,
    output logic                  o_frame
);

    localparam int unsigned CNT_W = safe_width(SCAN_DIV);

    // On-window lengths; guarded so an illegal parameter set cannot underflow.
    localparam int unsigned WIN_FULL    = (SCAN_DIV > DEAD_CYCLES) ? (SCAN_DIV - DEAD_CYCLES) : 1;
    localparam int unsigned WIN_DIM_RAW = WIN_FULL >> DIM_SHIFT;
    localparam int unsigned WIN_DIM     = (WIN_DIM_RAW == 0) ? 1 : WIN_DIM_RAW;
    localparam int unsigned END_FULL    = DEAD_CYCLES + WIN_FULL;
    localparam int unsigned END_DIM     = DEAD_CYCLES + WIN_DIM;

    localparam logic [NUM_DIGITS-1:0] ALL_OFF = NUM_DIGITS'(all_off(NUM_DIGITS));

    // Parameter legality, rejected at elaboration.
    if (NUM_DIGITS < 2) begin : gBadDigitsLow
        $error("fnd_scan_controller: NUM_DIGITS must be at least 2");
    end
    if (NUM_DIGITS > MAX_DIGITS) begin : gBadDigitsHigh
        $error("fnd_scan_controller: NUM_DIGITS exceeds MAX_DIGITS");
    end
    if (DEAD_CYCLES < 1) begin : gBadDead
        $error("fnd_scan_controller: DEAD_CYCLES must be at least 1");
    end
    if (SCAN_DIV <= DEAD_CYCLES + 1) begin : gBadDiv
        $error("fnd_scan_controller: SCAN_DIV must exceed DEAD_CYCLES+1");
    end

    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      sel;
    logic                  slotWrap;
    logic                  frameWrap;
    logic                  tickPend;
    logic                  framePend;
    logic [31:0]           cntWide;
    slot_phase_e           slotPhase;
    logic [NUM_DIGITS-1:0] nextDigits;

    scan_prescaler #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) uPrescaler (
        .clk         (i_clk),
        .reset       (i_reset),
        .cnt         (cnt),
        .sel         (sel),
        .slotWrap_c  (slotWrap),
        .frameWrap_c (frameWrap)
    );

    // Decode slot phase from the count and build the next digit-enable pattern.
    always_comb begin
        cntWide    = 32'(cnt);
        slotPhase  = PHASE_DEAD;
        nextDigits = ALL_OFF;
        if (cntWide < DEAD_CYCLES) begin
            slotPhase = PHASE_DEAD;
        end else if (cntWide < (i_SW_FndLight ? END_DIM : END_FULL)) begin
            slotPhase = PHASE_ON;
        end else begin
            slotPhase = PHASE_TAIL;
        end
        if ((slotPhase == PHASE_ON) && !i_en && !i_digit_mask[sel]) begin
            nextDigits[sel] = ~FND_ACTIVE_LOW;
        end
    end

    // Output registers; wrap strobes are delayed one stage to line up with o_select.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tickPend        <= 1'b0;
            framePend       <= 1'b0;
            o_digitPosition <= ALL_OFF;
            o_select        <= '0;
            o_tick          <= 1'b0;
            o_frame         <= 1'b0;
        end else begin
            tickPend        <= slotWrap;
            framePend       <= frameWrap;
            o_digitPosition <= nextDigits;
            o_select        <= sel;
            o_tick          <= tickPend;
            o_frame         <= framePend;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized scoreboard bench for fnd_scan_controller (6-digit and 3-digit instances).
module tb_fnd_scan_controller;

    localparam int unsigned SD = 8;
    localparam int unsigned DC = 2;
    localparam int unsigned DS = 1;

    typedef struct packed {
        logic [7:0] dig;
        logic [2:0] sel;
        logic       tick;
        logic       frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dim = 1'b0;
    logic [5:0] maskA = '0;
    logic [2:0] maskB = '0;

    logic [5:0] digA;
    logic [2:0] selA;
    logic       tickA, frameA;
    logic [2:0] digB;
    logic [1:0] selB;
    logic       tickB, frameB;

    exp_t qA[$];
    exp_t qB[$];
    int   checks = 0;
    int   failures = 0;
    int unsigned t = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .NUM_DIGITS(6), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .DIM_SHIFT(DS)
    ) dutA (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_SW_FndLight(dim),
        .i_digit_mask(maskA), .o_digitPosition(digA), .o_select(selA),
        .o_tick(tickA), .o_frame(frameA)
    );

    fnd_scan_controller #(
        .NUM_DIGITS(3), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .DIM_SHIFT(DS)
    ) dutB (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_SW_FndLight(dim),
        .i_digit_mask(maskB), .o_digitPosition(digB), .o_select(selB),
        .o_tick(tickB), .o_frame(frameB)
    );

    // Reference: output after an edge, from elapsed clock count since reset.
    function automatic exp_t model(input int unsigned n, input int unsigned tt,
                                   input bit rst, input bit e, input bit d,
                                   input logic [7:0] m);
        exp_t x;
        int unsigned c, s, w, wd;
        x.dig   = 8'((1 << n) - 1);
        x.sel   = '0;
        x.tick  = 1'b0;
        x.frame = 1'b0;
        if (!rst) begin
            c  = tt % SD;
            s  = (tt / SD) % n;
            wd = (SD - DC) >> DS;
            if (wd == 0) wd = 1;
            w  = d ? wd : (SD - DC);
            if (c >= DC && c < DC + w && !e && !m[s]) x.dig[s] = 1'b0;
            x.sel   = 3'(s);
            x.tick  = (c == 0) && (tt != 0);
            x.frame = x.tick && (s == 0);
        end
        return x;
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for both instances.
    task automatic step(input bit r, input bit e, input bit d, input logic [5:0] m);
        @(negedge clk);
        reset = r;
        en    = e;
        dim   = d;
        maskA = m;
        maskB = m[2:0];
        qA.push_back(model(6, t, r, e, d, {2'b00, m}));
        qB.push_back(model(3, t, r, e, d, {5'b00000, m[2:0]}));
        t = r ? 0 : t + 1;
    endtask

    // Monitor: compare DUT outputs after each edge against queued expectations.
    initial begin : monitor
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qA.size() > 0) begin
                ea = qA.pop_front();
                checks++;
                if (digA !== ea.dig[5:0] || selA !== ea.sel || tickA !== ea.tick || frameA !== ea.frame) begin
                    failures++;
                    $display("FAIL dutA_out t=%0t dig=%b exp=%b sel=%0d exp=%0d tick=%b exp=%b frame=%b exp=%b",
                             $time, digA, ea.dig[5:0], selA, ea.sel, tickA, ea.tick, frameA, ea.frame);
                end
                checks++;
                if ($countones(~digA) > 1) begin
                    failures++;
                    $display("FAIL dutA_overlap t=%0t dig=%b required at most one low bit", $time, digA);
                end
            end
            if (qB.size() > 0) begin
                eb = qB.pop_front();
                checks++;
                if (digB !== eb.dig[2:0] || selB !== eb.sel[1:0] || tickB !== eb.tick || frameB !== eb.frame) begin
                    failures++;
                    $display("FAIL dutB_out t=%0t dig=%b exp=%b sel=%0d exp=%0d tick=%b exp=%b frame=%b exp=%b",
                             $time, digB, eb.dig[2:0], selB, eb.sel[1:0], tickB, eb.tick, frameB, eb.frame);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin : stimulus
        int guard;
        repeat (3) step(1'b1, 1'b0, 1'b0, 6'b000000);
        repeat (100) step(1'b0, 1'b0, 1'b0, 6'b000000);
        repeat (60) step(1'b0, 1'b0, 1'b1, 6'b000000);
        repeat (40) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'b000000);
        repeat (20) step(1'b0, 1'b0, 1'b0, 6'b000100);
        repeat (10) step(1'b0, 1'b1, 1'b0, 6'b000100);
        repeat (60) step(1'b0, 1'b0, 1'b0, 6'b000100);
        repeat (10) step(1'b0, 1'b1, 1'b1, 6'b000100);
        repeat (30) step(1'b0, 1'b0, 1'b1, 6'b000100);

        guard = 0;
        while (!((t % SD) == 4 && ((t / SD) % 6) == 4) && guard < 200) begin
            step(1'b0, 1'b0, 1'b0, 6'b000000);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL reach_digit4_on guard=%0d required below 200", guard);
        end
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        repeat (60) step(1'b0, 1'b0, 1'b0, 6'b000000);

        repeat (400) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000);
        end
        repeat (60) step(1'b0, 1'b0, 1'b0, 6'b000000);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            failures++;
            $display("FAIL queue_drain pendingA=%0d pendingB=%0d required 0", qA.size(), qB.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time=%0t required finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
